// File: rtl/l2_arb.sv
// Arbitrates I-side line fills and D-side loads/stores onto a single L2 port.
// One transaction in flight at a time; a latched flush drains the port before any new grant.
module l2_arb #(
  parameter int M_WIDTH = 32,
  parameter int CL_BITS = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               l1i_req,
  input  logic [M_WIDTH-1:0] l1i_addr,
  output logic               l1i_rsp_valid,
  output logic [CL_BITS-1:0] l1i_rsp_data,
  input  logic               l1d_req,
  input  logic [M_WIDTH-1:0] l1d_addr,
  input  logic [3:0]         l1d_opcode,
  input  logic [CL_BITS-1:0] l1d_store_data,
  output logic               l1d_rsp_valid,
  output logic [CL_BITS-1:0] l1d_rsp_data,
  output logic               l2_req,
  output logic [M_WIDTH-1:0] l2_addr,
  output logic [3:0]         l2_opcode,
  output logic [CL_BITS-1:0] l2_store_data,
  input  logic               l2_ack,
  input  logic               l2_rsp_valid,
  input  logic [CL_BITS-1:0] l2_rsp_data,
  input  logic               flush_req,
  input  logic               flush_done,
  output logic               busy,
  output logic               proto_err,
  output logic [63:0]        i_grants,
  output logic [63:0]        d_grants
);

  localparam int OFF_BITS = $clog2(CL_BITS / 8);
  localparam logic [M_WIDTH-1:0] ADDR_MASK = {{(M_WIDTH - OFF_BITS){1'b1}}, {OFF_BITS{1'b0}}};
  localparam logic [3:0] OP_LOAD = 4'd4;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_RSP = 2'd2, FLUSH = 2'd3} state_t;

  state_t             state_r, state_s;
  logic               i_pend_r, i_pend_s, d_pend_r, d_pend_s;
  logic [M_WIDTH-1:0] i_addr_r, i_addr_s, d_addr_r, d_addr_s;
  logic [3:0]         d_op_r, d_op_s;
  logic [CL_BITS-1:0] d_data_r, d_data_s;
  logic               flush_r, flush_s;
  logic               last_gnt_r, last_gnt_s;  // 1 = D side was granted last
  logic               gnt_d_r, gnt_d_s;        // side owning the in-flight transaction
  logic               l2_req_r, l2_req_s;
  logic [M_WIDTH-1:0] l2_addr_r, l2_addr_s;
  logic [3:0]         l2_opcode_r, l2_opcode_s;
  logic [CL_BITS-1:0] l2_store_data_r, l2_store_data_s;
  logic               i_rsp_valid_r, i_rsp_valid_s, d_rsp_valid_r, d_rsp_valid_s;
  logic [CL_BITS-1:0] i_rsp_data_r, i_rsp_data_s, d_rsp_data_r, d_rsp_data_s;
  logic               proto_err_r, proto_err_s;
  logic [63:0]        i_grants_r, i_grants_s, d_grants_r, d_grants_s;
  logic               busy_r, busy_s;
  logic               i_eff_s, d_eff_s, complete_s, rsp_err_s;

  // Next-state logic: slot capture, arbitration, L2 handshake and completion.
  always_comb begin
    state_s         = state_r;
    i_pend_s        = i_pend_r;
    i_addr_s        = i_addr_r;
    d_pend_s        = d_pend_r;
    d_addr_s        = d_addr_r;
    d_op_s          = d_op_r;
    d_data_s        = d_data_r;
    flush_s         = flush_r | flush_req;
    last_gnt_s      = last_gnt_r;
    gnt_d_s         = gnt_d_r;
    l2_req_s        = l2_req_r;
    l2_addr_s       = l2_addr_r;
    l2_opcode_s     = l2_opcode_r;
    l2_store_data_s = l2_store_data_r;
    i_rsp_valid_s   = 1'b0;
    d_rsp_valid_s   = 1'b0;
    i_rsp_data_s    = i_rsp_data_r;
    d_rsp_data_s    = d_rsp_data_r;
    proto_err_s     = proto_err_r;
    i_grants_s      = i_grants_r;
    d_grants_s      = d_grants_r;
    complete_s      = 1'b0;
    rsp_err_s       = 1'b0;
    i_eff_s         = i_pend_r | l1i_req;
    d_eff_s         = d_pend_r | l1d_req;

    // A request into an occupied slot is dropped and flagged.
    if (l1i_req && i_pend_r) begin
      proto_err_s = 1'b1;
    end else if (l1i_req) begin
      i_pend_s = 1'b1;
      i_addr_s = l1i_addr;
    end else begin
      i_pend_s = i_pend_r;
    end

    if (l1d_req && d_pend_r) begin
      proto_err_s = 1'b1;
    end else if (l1d_req) begin
      d_pend_s = 1'b1;
      d_addr_s = l1d_addr;
      d_op_s   = l1d_opcode;
      d_data_s = l1d_store_data;
    end else begin
      d_pend_s = d_pend_r;
    end

    case (state_r)
      IDLE: begin
        rsp_err_s = l2_rsp_valid;
        if (flush_r) begin
          state_s = FLUSH;
        end else if (i_eff_s && (!d_eff_s || last_gnt_r)) begin
          state_s         = ISSUE;
          l2_req_s        = 1'b1;
          l2_addr_s       = (i_pend_r ? i_addr_r : l1i_addr) & ADDR_MASK;
          l2_opcode_s     = OP_LOAD;
          l2_store_data_s = {CL_BITS{1'b0}};
          last_gnt_s      = 1'b0;
          gnt_d_s         = 1'b0;
          i_grants_s      = i_grants_r + 64'd1;
        end else if (d_eff_s) begin
          state_s         = ISSUE;
          l2_req_s        = 1'b1;
          l2_addr_s       = (d_pend_r ? d_addr_r : l1d_addr) & ADDR_MASK;
          l2_opcode_s     = d_pend_r ? d_op_r : l1d_opcode;
          l2_store_data_s = d_pend_r ? d_data_r : l1d_store_data;
          last_gnt_s      = 1'b1;
          gnt_d_s         = 1'b1;
          d_grants_s      = d_grants_r + 64'd1;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (l2_ack) begin
          l2_req_s   = 1'b0;
          complete_s = l2_rsp_valid;
          state_s    = l2_rsp_valid ? IDLE : WAIT_RSP;
        end else begin
          rsp_err_s = l2_rsp_valid;
        end
      end
      WAIT_RSP: begin
        complete_s = l2_rsp_valid;
        state_s    = l2_rsp_valid ? IDLE : WAIT_RSP;
      end
      FLUSH: begin
        rsp_err_s = l2_rsp_valid;
        if (flush_done) begin
          flush_s = flush_req;
          state_s = IDLE;
        end else begin
          state_s = FLUSH;
        end
      end
      default: state_s = IDLE;
    endcase

    if (rsp_err_s) begin
      proto_err_s = 1'b1;
    end else begin
      proto_err_s = proto_err_s;
    end

    // Response is delivered one cycle after l2_rsp_valid and frees the owner's slot.
    if (complete_s && gnt_d_r) begin
      d_rsp_valid_s = 1'b1;
      d_rsp_data_s  = l2_rsp_data;
      d_pend_s      = 1'b0;
    end else if (complete_s) begin
      i_rsp_valid_s = 1'b1;
      i_rsp_data_s  = l2_rsp_data;
      i_pend_s      = 1'b0;
    end else begin
      d_rsp_valid_s = 1'b0;
    end

    busy_s = (state_s != IDLE) | i_pend_s | d_pend_s | flush_s;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= IDLE;
      i_pend_r        <= 1'b0;
      i_addr_r        <= {M_WIDTH{1'b0}};
      d_pend_r        <= 1'b0;
      d_addr_r        <= {M_WIDTH{1'b0}};
      d_op_r          <= 4'd0;
      d_data_r        <= {CL_BITS{1'b0}};
      flush_r         <= 1'b0;
      last_gnt_r      <= 1'b1;
      gnt_d_r         <= 1'b0;
      l2_req_r        <= 1'b0;
      l2_addr_r       <= {M_WIDTH{1'b0}};
      l2_opcode_r     <= 4'd0;
      l2_store_data_r <= {CL_BITS{1'b0}};
      i_rsp_valid_r   <= 1'b0;
      i_rsp_data_r    <= {CL_BITS{1'b0}};
      d_rsp_valid_r   <= 1'b0;
      d_rsp_data_r    <= {CL_BITS{1'b0}};
      proto_err_r     <= 1'b0;
      i_grants_r      <= 64'd0;
      d_grants_r      <= 64'd0;
      busy_r          <= 1'b0;
    end else begin
      state_r         <= state_s;
      i_pend_r        <= i_pend_s;
      i_addr_r        <= i_addr_s;
      d_pend_r        <= d_pend_s;
      d_addr_r        <= d_addr_s;
      d_op_r          <= d_op_s;
      d_data_r        <= d_data_s;
      flush_r         <= flush_s;
      last_gnt_r      <= last_gnt_s;
      gnt_d_r         <= gnt_d_s;
      l2_req_r        <= l2_req_s;
      l2_addr_r       <= l2_addr_s;
      l2_opcode_r     <= l2_opcode_s;
      l2_store_data_r <= l2_store_data_s;
      i_rsp_valid_r   <= i_rsp_valid_s;
      i_rsp_data_r    <= i_rsp_data_s;
      d_rsp_valid_r   <= d_rsp_valid_s;
      d_rsp_data_r    <= d_rsp_data_s;
      proto_err_r     <= proto_err_s;
      i_grants_r      <= i_grants_s;
      d_grants_r      <= d_grants_s;
      busy_r          <= busy_s;
    end
  end

  assign l1i_rsp_valid = i_rsp_valid_r;
  assign l1i_rsp_data  = i_rsp_data_r;
  assign l1d_rsp_valid = d_rsp_valid_r;
  assign l1d_rsp_data  = d_rsp_data_r;
  assign l2_req        = l2_req_r;
  assign l2_addr       = l2_addr_r;
  assign l2_opcode     = l2_opcode_r;
  assign l2_store_data = l2_store_data_r;
  assign busy          = busy_r;
  assign proto_err     = proto_err_r;
  assign i_grants      = i_grants_r;
  assign d_grants      = d_grants_r;

endmodule

// File: doc/l2_arb.md
L2_ARB -- requirements
Module: l2_arb

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- M_WIDTH, 32, physical address width.
- CL_BITS, 128, cache-line data width.
REQ-002 Ports (name  direction  width  meaning), one per line:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- l1i_req  in  1  single-cycle I-side line-fill request pulse.
- l1i_addr  in  M_WIDTH  I-side address, sampled with l1i_req.
- l1i_rsp_valid  out  1  single-cycle I-side response pulse.
- l1i_rsp_data  out  CL_BITS  I-side fill data, valid with l1i_rsp_valid.
- l1d_req  in  1  single-cycle D-side request pulse.
- l1d_addr  in  M_WIDTH  D-side address, sampled with l1d_req.
- l1d_opcode  in  4  D-side opcode (4 = load, 7 = store), sampled with l1d_req.
- l1d_store_data  in  CL_BITS  D-side store line, sampled with l1d_req.
- l1d_rsp_valid  out  1  single-cycle D-side response pulse (loads and stores).
- l1d_rsp_data  out  CL_BITS  D-side load data.
- l2_req  out  1  request to the L2; level, held until acknowledged.
- l2_addr / l2_opcode / l2_store_data  out  M_WIDTH/4/CL_BITS  request payload, stable while l2_req = 1.
- l2_ack  in  1  L2 accepted the current request.
- l2_rsp_valid  in  1  L2 completion pulse.
- l2_rsp_data  in  CL_BITS  L2 load data.
- flush_req  in  1  pulse: the L2 flush is requested.
- flush_done  in  1  pulse: the L2 flush is finished.
- busy  out  1  state != IDLE or any request pending.
- proto_err  out  1  sticky protocol-violation flag.
- i_grants / d_grants  out  64 each  grant counters.

Function
REQ-003 Each side has a pending slot (valid, address; the D side also holds opcode and store data), loaded on its req pulse.
REQ-004 A req pulse on a side whose slot is already pending or in flight shall be dropped and shall set proto_err.
REQ-005 FSM states: IDLE, ISSUE, WAIT_RSP, FLUSH.
REQ-006 IDLE: the effective request per side = pending | same-cycle req; a latched flush takes priority over both.
REQ-007 Both sides requesting: grant the side opposite last_gnt. One side requesting: grant it. The granted side's last_gnt is updated.
REQ-008 On grant: l2_req = 1 and payload registered on the next edge (request pulse at cycle t gives l2_req high in cycle t+1); granted counter +1; next state ISSUE.
REQ-009 The l2_addr low log2(CL_BITS/8) bits shall be forced to 0.
REQ-010 I-side grants shall drive l2_opcode = 4.
REQ-011 ISSUE: hold l2_req and payload until l2_ack = 1. On l2_ack: l2_req = 0 next cycle, go to WAIT_RSP; if l2_rsp_valid in the same cycle, complete directly (REQ-012).
REQ-012 WAIT_RSP: on l2_rsp_valid, one cycle later pulse the granted side's rsp_valid with rsp_data = registered l2_rsp_data, clear that slot, go to IDLE. IDLE may grant again in the cycle the rsp_valid is output.
REQ-013 l2_rsp_valid in IDLE, FLUSH, or ISSUE before l2_ack shall be ignored and shall set proto_err.
REQ-014 flush_req shall be latched in any state. It is taken from IDLE only, after any in-flight transaction completes; next state FLUSH.
REQ-015 FLUSH: no grants; requests still latch into slots. flush_done clears the latch and returns to IDLE.
REQ-016 Counters wrap modulo 2^64.
REQ-017 rsp_data outputs hold their last value between pulses.

Reset
REQ-018 On reset, synchronously:
- state = IDLE; slots, flush latch and proto_err = 0.
- last_gnt = D, so the first tie goes to I.
- All outputs 0, including counters and data.
REQ-019 Reset in any state aborts the transaction without a response; inputs sampled during reset are ignored.

Verification
REQ-020 l1i_req pulse with addr 0x1234 -> l2_req = 1 next cycle, l2_addr 0x1230 (CL_BITS=128), opcode 4; ack, then rsp data D, -> l1i_rsp_valid one cycle after l2_rsp_valid with data D; i_grants = 1.
REQ-021 l1i_req and l1d_req in the same cycle after reset -> I granted first, D issued after I completes; next simultaneous pair -> D first.
REQ-022 D store (opcode 7) with l2_ack and l2_rsp_valid in the same cycle -> l1d_rsp_valid exactly one cycle later, FSM back to IDLE.
REQ-023 flush_req during WAIT_RSP while D is pending -> current response delivered, FLUSH entered, D not issued until flush_done, then D issued.
REQ-024 Second l1i_req while I in flight -> dropped, proto_err = 1; stray l2_rsp_valid in IDLE -> no rsp pulse.
REQ-025 Reset asserted in ISSUE -> next cycle l2_req = 0, busy = 0, counters 0, no rsp_valid.
